// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: resolves memory-wait, branch and RAW-hazard
// stalls into freeze/flush controls, with a memory timeout watchdog and perf counters.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic             two_src,
   input  logic             exe_wb_en,
   input  logic [3:0]       exe_dest,
   input  logic             exe_mem_r,
   input  logic             mem_wb_en,
   input  logic [3:0]       mem_dest,
   input  logic             fwd_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_freeze,
   output logic             if_freeze,
   output logic             if_flush,
   output logic             id_flush,
   output logic             exe_freeze,
   output logic             mem_freeze,
   output logic             hazard,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic raw_hazard;
   logic mem_stall;
   logic pc_fr, if_fr, if_fl, id_fl, exe_fr, mem_fr;

   // With forwarding only a load feeding the very next instruction must stall.
   always_comb begin
      if (fwd_en) begin
         raw_hazard = exe_mem_r & ((src1 == exe_dest) | (two_src & (src2 == exe_dest)));
      end else begin
         raw_hazard = (exe_wb_en & (src1 == exe_dest))
                    | (two_src & exe_wb_en & (src2 == exe_dest))
                    | (mem_wb_en & (src1 == mem_dest))
                    | (two_src & mem_wb_en & (src2 == mem_dest));
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      mem_stall  = 1'b0;
      case (state_q)
         RUN: begin
            mem_stall = mem_req & ~mem_ready;
            if (mem_stall) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         MEM_WAIT: begin
            mem_stall = ~mem_ready;
            if (mem_ready) begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == TIMEOUT_M1) begin
               state_d   = ERR;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ERR: begin
            mem_stall = 1'b1;
            mem_err_d = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   // Every flush also freezes IF/ID: the register only honours flush while frozen.
   always_comb begin
      pc_fr  = 1'b0;
      if_fr  = 1'b0;
      if_fl  = 1'b0;
      id_fl  = 1'b0;
      exe_fr = 1'b0;
      mem_fr = 1'b0;
      if (mem_stall) begin
         pc_fr  = 1'b1;
         if_fr  = 1'b1;
         exe_fr = 1'b1;
         mem_fr = 1'b1;
      end else if (branch_taken) begin
         if_fr = 1'b1;
         if_fl = 1'b1;
         id_fl = 1'b1;
      end else if (raw_hazard) begin
         pc_fr = 1'b1;
         if_fr = 1'b1;
         id_fl = 1'b1;
      end
   end

   assign pc_freeze  = rst & pc_fr;
   assign if_freeze  = rst & if_fr;
   assign if_flush   = rst & if_fl;
   assign id_flush   = rst & id_fl;
   assign exe_freeze = rst & exe_fr;
   assign mem_freeze = rst & mem_fr;
   assign hazard     = rst & raw_hazard;
   assign mem_err    = mem_err_q;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;
   assign state_dbg  = state_q;

   // Counters saturate at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_freeze && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (if_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule
